// File: rtl/spi_master.sv
// SPI mode-0 master: shifts one PACKET_WIDTH-bit packet MSB first, framed by an active-low SSEL.
// Define SPI_MASTER_BURST_EN to allow back-to-back packets without releasing SSEL.
`timescale 1ns/1ps
module spi_master #(
  parameter int WORD_WIDTH   = 36,
  parameter int PACKET_WIDTH = WORD_WIDTH + 4,
  parameter int CLK_DIV      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_WIDTH-1:0] tx_data,
  input  logic                    start,
  output logic                    busy,
  output logic [PACKET_WIDTH-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    spi_SCLK,
  output logic                    spi_SSEL,
  output logic                    spi_MOSI,
  input  logic                    spi_MISO
);

  localparam int DW = 8;
  localparam int BW = $clog2(PACKET_WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(PACKET_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PACKET_WIDTH-1:0] tx_q, tx_d;
  logic [PACKET_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                    sclk_q, sclk_d;
  logic                    ssel_q, ssel_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    div_done;

  assign div_done = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_done ? '0 : div_q + 1'b1;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    ssel_d     = ssel_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          state_d    = SETUP;
          tx_d       = tx_data;
          bit_d      = BIT_TOP;
          rx_shift_d = '0;
          ssel_d     = 1'b0;
          busy_d     = 1'b1;
          mosi_d     = tx_data[PACKET_WIDTH-1];
        end
      end
      SETUP: begin
        if (div_done) begin
          state_d    = SHIFT_HI;
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[PACKET_WIDTH-2:0], spi_MISO};
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          state_d = SHIFT_LO;
          sclk_d  = 1'b0;
          // The last bit holds MOSI through its low half; there is no lower bit to present.
          if (bit_q != '0) begin
            mosi_d = tx_q[bit_q - 1'b1];
          end
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          if (bit_q != '0) begin
            state_d    = SHIFT_HI;
            sclk_d     = 1'b1;
            bit_d      = bit_q - 1'b1;
            rx_shift_d = {rx_shift_q[PACKET_WIDTH-2:0], spi_MISO};
          end else begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
`ifdef SPI_MASTER_BURST_EN
            // Chained packet: SSEL stays low and the setup half-period is reused before the first edge.
            if (start) begin
              state_d    = SETUP;
              tx_d       = tx_data;
              bit_d      = BIT_TOP;
              rx_shift_d = '0;
              mosi_d     = tx_data[PACKET_WIDTH-1];
            end else begin
              state_d = GAP;
              ssel_d  = 1'b1;
              mosi_d  = 1'b0;
            end
`else
            state_d = GAP;
            ssel_d  = 1'b1;
            mosi_d  = 1'b0;
`endif
          end
        end
      end
      GAP: begin
        if (div_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      ssel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      ssel_q     <= ssel_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_SCLK = sclk_q;
  assign spi_SSEL = ssel_q;
  assign spi_MOSI = mosi_q;

endmodule
